// File: rtl/stb_meas_pkg.sv
// Shared types and constants for the stb_gen measurement sequencer.
// Status codes are visible to software through the measure unit register block.
package stb_meas_pkg;

   typedef enum logic [2:0] {
      ST_NONE     = 3'd0,
      ST_OK       = 3'd1,
      ST_TIMEOUT  = 3'd2,
      ST_ERR      = 3'd3,
      ST_UNSTABLE = 3'd4,
      ST_LOST     = 3'd5,
      ST_ABORT    = 3'd6
   } status_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RST   = 3'd1,
      ARM   = 3'd2,
      WAIT  = 3'd3,
      CHECK = 3'd4,
      RUN   = 3'd5,
      FAIL  = 3'd6
   } state_e;

   localparam int RST_CYCLES = 2;

endpackage

// File: rtl/stb_meas_timer.sv
// Loadable down-counter shared by the RST, ARM and WAIT states.
// done is high while the count is zero; the count saturates there.
module stb_meas_timer #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - WIDTH'(1);
      end
   end

   assign done = (count_reg == '0);

endmodule

// File: rtl/stb_meas_seq.sv
// Measurement sequencer for one stb_gen: reset, arm, two period measurements,
// stability check, then strobe enable; bounded retry on failures.
module stb_meas_seq
   import stb_meas_pkg::*;
#(
   parameter int T_CNT_WIDTH = 32,
   parameter int TO_WIDTH    = 24,
   parameter int DET_WIDTH   = 16,
   parameter int RETRY_WIDTH = 4
) (
   input  logic                   clk_i,
   input  logic                   arst_ni,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [DET_WIDTH-1:0]   cfg_det_cycles_i,
   input  logic [TO_WIDTH-1:0]    cfg_timeout_i,
   input  logic [RETRY_WIDTH-1:0] cfg_retries_i,
   input  logic [T_CNT_WIDTH-1:0] cfg_tol_i,
   output logic                   stb_rst_o,
   output logic                   stb_run_det_o,
   output logic                   stb_oe_o,
   input  logic                   stb_rdy_i,
   input  logic                   stb_err_i,
   input  logic [T_CNT_WIDTH-1:0] stb_period_i,
   output logic                   busy_o,
   output logic                   locked_o,
   output logic                   done_o,
   output logic [2:0]             status_o,
   output logic [T_CNT_WIDTH-1:0] period_o,
   output logic [RETRY_WIDTH-1:0] retry_cnt_o
);

   localparam int TMR_W = (TO_WIDTH > DET_WIDTH) ? TO_WIDTH : DET_WIDTH;

   state_e                 state_reg, state_next;
   status_e                status_reg, status_next;
   logic [RETRY_WIDTH-1:0] retry_reg, retry_next;
   logic                   meas_idx_reg, meas_idx_next;
   logic [T_CNT_WIDTH-1:0] p1_reg, p1_next;
   logic [T_CNT_WIDTH-1:0] p2_reg, p2_next;
   logic [T_CNT_WIDTH-1:0] period_reg, period_next;

   logic stb_rst_reg, stb_rst_next;
   logic run_det_reg, run_det_next;
   logic oe_reg, oe_next;
   logic busy_reg, busy_next;
   logic locked_reg, locked_next;
   logic done_reg, done_next;

   logic                   abort_take;
   logic                   fail_evt;
   status_e                fail_code;
   logic [T_CNT_WIDTH:0]   diff;
   logic [DET_WIDTH-1:0]   det_m1;
   logic                   tmr_load;
   logic [TMR_W-1:0]       tmr_val;
   logic                   tmr_done;

   stb_meas_timer #(
      .WIDTH (TMR_W)
   ) u_timer (
      .clk      (clk_i),
      .rst_n    (arst_ni),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Extra bit keeps the subtraction free of wrap regardless of operand order.
   always_comb begin
      if (p1_reg >= p2_reg) begin
         diff = {1'b0, p1_reg} - {1'b0, p2_reg};
      end else begin
         diff = {1'b0, p2_reg} - {1'b0, p1_reg};
      end
   end

   assign det_m1 = (cfg_det_cycles_i == '0) ? '0 : cfg_det_cycles_i - DET_WIDTH'(1);

   always_comb begin
      state_next    = state_reg;
      status_next   = status_reg;
      retry_next    = retry_reg;
      meas_idx_next = meas_idx_reg;
      p1_next       = p1_reg;
      p2_next       = p2_reg;
      period_next   = period_reg;
      abort_take    = 1'b0;
      fail_evt      = 1'b0;
      fail_code     = ST_NONE;

      if (abort_i && (state_reg != IDLE)) begin
         abort_take  = 1'b1;
         state_next  = IDLE;
         status_next = ST_ABORT;
      end else begin
         case (state_reg)
            IDLE, FAIL: begin
               if (start_i) begin
                  retry_next    = '0;
                  meas_idx_next = 1'b0;
                  state_next    = RST;
               end
            end
            RST: begin
               if (tmr_done) state_next = ARM;
            end
            ARM: begin
               if (tmr_done) state_next = WAIT;
            end
            WAIT: begin
               if (stb_err_i) begin
                  fail_evt  = 1'b1;
                  fail_code = ST_ERR;
               end else if (stb_rdy_i) begin
                  if (!meas_idx_reg) begin
                     p1_next       = stb_period_i;
                     meas_idx_next = 1'b1;
                     state_next    = RST;
                  end else begin
                     p2_next    = stb_period_i;
                     state_next = CHECK;
                  end
               end else if ((cfg_timeout_i != '0) && tmr_done) begin
                  fail_evt  = 1'b1;
                  fail_code = ST_TIMEOUT;
               end
            end
            CHECK: begin
               if (diff <= {1'b0, cfg_tol_i}) begin
                  period_next = p2_reg;
                  status_next = ST_OK;
                  state_next  = RUN;
               end else begin
                  fail_evt  = 1'b1;
                  fail_code = ST_UNSTABLE;
               end
            end
            RUN: begin
               if (stb_err_i) begin
                  status_next = ST_LOST;
                  state_next  = FAIL;
               end
            end
            default: state_next = IDLE;
         endcase

         if (fail_evt) begin
            if (retry_reg < cfg_retries_i) begin
               retry_next    = retry_reg + RETRY_WIDTH'(1);
               meas_idx_next = 1'b0;
               state_next    = RST;
            end else begin
               status_next = fail_code;
               state_next  = FAIL;
            end
         end
      end
   end

   // Outputs are registered from the next state so they line up with state_reg.
   always_comb begin
      tmr_load = (state_next != state_reg);
      case (state_next)
         RST:     tmr_val = TMR_W'(RST_CYCLES - 1);
         ARM:     tmr_val = TMR_W'(det_m1);
         WAIT:    tmr_val = TMR_W'(cfg_timeout_i);
         default: tmr_val = '0;
      endcase
      stb_rst_next = (state_next == RST) || abort_take;
      run_det_next = (state_next == ARM);
      oe_next      = (state_next == RUN);
      locked_next  = (state_next == RUN);
      busy_next    = (state_next != IDLE) && (state_next != FAIL);
      done_next    = (state_next != state_reg) &&
                     ((state_next == RUN) || (state_next == FAIL));
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_reg    <= IDLE;
         status_reg   <= ST_NONE;
         retry_reg    <= '0;
         meas_idx_reg <= 1'b0;
         p1_reg       <= '0;
         p2_reg       <= '0;
         period_reg   <= '0;
         stb_rst_reg  <= 1'b0;
         run_det_reg  <= 1'b0;
         oe_reg       <= 1'b0;
         busy_reg     <= 1'b0;
         locked_reg   <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         status_reg   <= status_next;
         retry_reg    <= retry_next;
         meas_idx_reg <= meas_idx_next;
         p1_reg       <= p1_next;
         p2_reg       <= p2_next;
         period_reg   <= period_next;
         stb_rst_reg  <= stb_rst_next;
         run_det_reg  <= run_det_next;
         oe_reg       <= oe_next;
         busy_reg     <= busy_next;
         locked_reg   <= locked_next;
         done_reg     <= done_next;
      end
   end

   assign stb_rst_o     = stb_rst_reg;
   assign stb_run_det_o = run_det_reg;
   assign stb_oe_o      = oe_reg;
   assign busy_o        = busy_reg;
   assign locked_o      = locked_reg;
   assign done_o        = done_reg;
   assign status_o      = status_reg;
   assign period_o      = period_reg;
   assign retry_cnt_o   = retry_reg;

endmodule

// File: tb/tb_stb_meas_seq.sv
// Directed bench for stb_meas_seq with a small behavioural stb_gen model
// that answers each run_det pulse with rdy and the next period from a table.
module tb_stb_meas_seq;

   logic        clk_i = 1'b0;
   logic        arst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic        abort_i = 1'b0;
   logic [15:0] cfg_det_cycles_i = 16'd0;
   logic [23:0] cfg_timeout_i = 24'd0;
   logic [3:0]  cfg_retries_i = 4'd0;
   logic [31:0] cfg_tol_i = 32'd0;
   logic        stb_rst_o, stb_run_det_o, stb_oe_o;
   logic        stb_rdy_i = 1'b0;
   logic        stb_err_i = 1'b0;
   logic [31:0] stb_period_i = 32'd0;
   logic        busy_o, locked_o, done_o;
   logic [2:0]  status_o;
   logic [31:0] period_o;
   logic [3:0]  retry_cnt_o;

   int n_assert = 0;
   int n_fail   = 0;
   int n_rst, n_det, n_oe, n_wait;

   logic [31:0] per_tab [8];
   int          per_idx = 0;
   int          cd = 0;
   logic        det_prev = 1'b0;
   logic        mute = 1'b0;

   stb_meas_seq dut (
      .clk_i            (clk_i),
      .arst_ni          (arst_ni),
      .start_i          (start_i),
      .abort_i          (abort_i),
      .cfg_det_cycles_i (cfg_det_cycles_i),
      .cfg_timeout_i    (cfg_timeout_i),
      .cfg_retries_i    (cfg_retries_i),
      .cfg_tol_i        (cfg_tol_i),
      .stb_rst_o        (stb_rst_o),
      .stb_run_det_o    (stb_run_det_o),
      .stb_oe_o         (stb_oe_o),
      .stb_rdy_i        (stb_rdy_i),
      .stb_err_i        (stb_err_i),
      .stb_period_i     (stb_period_i),
      .busy_o           (busy_o),
      .locked_o         (locked_o),
      .done_o           (done_o),
      .status_o         (status_o),
      .period_o         (period_o),
      .retry_cnt_o      (retry_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // stb_gen model: rdy rises 5 clocks after run_det falls, cleared by stb_rst.
   always @(negedge clk_i) begin
      if (!arst_ni || stb_rst_o) begin
         stb_rdy_i = 1'b0;
         cd = 0;
      end else if (det_prev && !stb_run_det_o && !mute) begin
         cd = 5;
      end else if (cd != 0) begin
         cd = cd - 1;
         if (cd == 0) begin
            stb_rdy_i    = 1'b1;
            stb_period_i = per_tab[per_idx];
            per_idx      = per_idx + 1;
         end
      end
      det_prev = stb_run_det_o;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic wait_det(input string tag, input logic lvl, input int max);
      bit found = 0;
      for (int i = 0; i < max; i++) begin
         if (stb_run_det_o === lvl) begin
            found = 1;
            break;
         end
         @(negedge clk_i);
      end
      if (!found) begin
         n_assert++;
         n_fail++;
         $display("FAIL %s: run_det never reached %0d within %0d cycles", tag, lvl, max);
      end
   endtask

   // Samples from the current negedge on, tallying control activity until done_o.
   task automatic wait_done(input string tag, input int max);
      bit found = 0;
      n_rst = 0; n_det = 0; n_oe = 0; n_wait = 0;
      for (int i = 0; i < max; i++) begin
         if (done_o === 1'b1) begin
            found = 1;
            break;
         end
         if (stb_rst_o) n_rst++;
         if (stb_run_det_o) n_det++;
         if (stb_oe_o) n_oe++;
         if (busy_o && !stb_rst_o && !stb_run_det_o && !stb_oe_o) n_wait++;
         @(negedge clk_i);
      end
      if (!found) begin
         n_assert++;
         n_fail++;
         $display("FAIL %s: done_o not seen within %0d cycles", tag, max);
      end
   endtask

   initial begin
      per_tab[0] = 32'd2500; per_tab[1] = 32'd2501;
      per_tab[2] = 32'd2500; per_tab[3] = 32'd2510;
      per_tab[4] = 32'd2500; per_tab[5] = 32'd2510;
      per_tab[6] = 32'd200;  per_tab[7] = 32'd200;

      // Reset state
      repeat (3) @(negedge clk_i);
      chk("rst_busy", busy_o, 0);
      chk("rst_status", status_o, 0);
      chk("rst_ctrl", {stb_rst_o, stb_run_det_o, stb_oe_o, locked_o, done_o}, 0);
      arst_ni = 1'b1;

      // Normal lock: two 2-clock resets, two 42-clock run_det pulses
      cfg_det_cycles_i = 16'd42; cfg_tol_i = 32'd1; cfg_timeout_i = 24'd0; cfg_retries_i = 4'd0;
      pulse_start();
      wait_done("lock", 400);
      $display("lock: status=%0d period=%0d rst=%0d det=%0d", status_o, period_o, n_rst, n_det);
      chk("lock_status", status_o, 1);
      chk("lock_period", period_o, 2501);
      chk("lock_locked", locked_o, 1);
      chk("lock_oe", stb_oe_o, 1);
      chk("lock_busy", busy_o, 1);
      chk("lock_rst_cycles", n_rst, 4);
      chk("lock_det_cycles", n_det, 84);
      @(negedge clk_i);
      chk("lock_done_once", done_o, 0);

      // Abort from RUN
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      $display("abort_run: status=%0d rst=%0d oe=%0d", status_o, stb_rst_o, stb_oe_o);
      chk("abrun_status", status_o, 6);
      chk("abrun_ctrl", {stb_rst_o, stb_oe_o, locked_o, done_o, busy_o}, 5'b10000);
      @(negedge clk_i);
      chk("abrun_rst_1clk", stb_rst_o, 0);

      // Unstable with one retry
      cfg_det_cycles_i = 16'd3; cfg_tol_i = 32'd2; cfg_retries_i = 4'd1;
      pulse_start();
      wait_done("unstable", 400);
      $display("unstable: status=%0d retry=%0d rst=%0d oe=%0d", status_o, retry_cnt_o, n_rst, n_oe);
      chk("unst_status", status_o, 4);
      chk("unst_retry", retry_cnt_o, 1);
      chk("unst_busy", busy_o, 0);
      chk("unst_oe_never", n_oe, 0);
      chk("unst_rst_cycles", n_rst, 8);
      chk("unst_period_kept", period_o, 2501);

      // Timeout: restart from FAIL, rdy never comes
      cfg_timeout_i = 24'd1000; cfg_retries_i = 4'd0; mute = 1'b1;
      pulse_start();
      wait_done("timeout", 3000);
      $display("timeout: status=%0d wait_cycles=%0d", status_o, n_wait);
      chk("to_status", status_o, 2);
      chk("to_wait_cycles", n_wait, 1001);
      chk("to_retry", retry_cnt_o, 0);
      chk("to_busy", busy_o, 0);

      // Error on first attempt, success on retry with tol=0
      cfg_timeout_i = 24'd0; cfg_retries_i = 4'd2; cfg_tol_i = 32'd0; mute = 1'b0;
      pulse_start();
      wait_det("err_arm", 1'b1, 50);
      wait_det("err_wait", 1'b0, 50);
      stb_err_i = 1'b1;
      @(negedge clk_i);
      stb_err_i = 1'b0;
      wait_done("err_retry", 400);
      $display("err_retry: status=%0d retry=%0d period=%0d", status_o, retry_cnt_o, period_o);
      chk("errr_status", status_o, 1);
      chk("errr_retry", retry_cnt_o, 1);
      chk("errr_period", period_o, 200);
      chk("errr_locked", locked_o, 1);

      // Lost lock in RUN
      @(negedge clk_i);
      stb_err_i = 1'b1;
      @(negedge clk_i);
      stb_err_i = 1'b0;
      $display("lost: status=%0d oe=%0d done=%0d", status_o, stb_oe_o, done_o);
      chk("lost_oe", stb_oe_o, 0);
      chk("lost_status", status_o, 5);
      chk("lost_done", done_o, 1);
      chk("lost_locked", locked_o, 0);
      @(negedge clk_i);
      chk("lost_done_once", done_o, 0);
      pulse_start();
      $display("restart: rst=%0d busy=%0d", stb_rst_o, busy_o);
      chk("restart_rst", stb_rst_o, 1);
      chk("restart_busy", busy_o, 1);
      chk("restart_retry", retry_cnt_o, 0);

      // Abort during ARM
      wait_det("abarm", 1'b1, 50);
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      $display("abort_arm: status=%0d rst=%0d det=%0d", status_o, stb_rst_o, stb_run_det_o);
      chk("abarm_det", stb_run_det_o, 0);
      chk("abarm_rst", stb_rst_o, 1);
      chk("abarm_status", status_o, 6);
      chk("abarm_done", done_o, 0);
      chk("abarm_busy", busy_o, 0);
      @(negedge clk_i);
      chk("abarm_rst_1clk", stb_rst_o, 0);

      // start and abort together in IDLE: start is taken
      start_i = 1'b1; abort_i = 1'b1; mute = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0; abort_i = 1'b0;
      $display("start_abort: busy=%0d rst=%0d status=%0d", busy_o, stb_rst_o, status_o);
      chk("sa_busy", busy_o, 1);
      chk("sa_rst", stb_rst_o, 1);
      chk("sa_status", status_o, 6);

      // Asynchronous reset while in WAIT
      wait_det("rw_arm", 1'b1, 50);
      wait_det("rw_wait", 1'b0, 50);
      repeat (2) @(negedge clk_i);
      arst_ni = 1'b0;
      #1;
      $display("async_rst: busy=%0d status=%0d period=%0d", busy_o, status_o, period_o);
      chk("ar_ctrl", {stb_rst_o, stb_run_det_o, stb_oe_o, busy_o, locked_o, done_o}, 0);
      chk("ar_status", status_o, 0);
      chk("ar_period", period_o, 0);
      chk("ar_retry", retry_cnt_o, 0);
      @(negedge clk_i);
      arst_ni = 1'b1;
      repeat (2) @(negedge clk_i);
      chk("ar_idle", {busy_o, stb_rst_o}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
